// File: rtl/conv_pool_engine.sv
// 3x3 convolution with ReLU/saturation, then optional 2x2 max-pool of each channel.
// Define CONV_POOL_FLATTEN_EN to add the FLAT_WR stage (pooled values also written to csel=9).
module conv_pool_engine #(
    parameter int IMG_W = 64,
    parameter int AW    = 12,
    parameter int NCH   = 2
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          ready_i,
    input  logic          mode_i,
    output logic          busy_o,
    output logic          done_o,
    input  logic          wld_i,
    input  logic [1:0]    wch_i,
    input  logic [3:0]    widx_i,
    input  logic [19:0]   wdata_i,
    output logic [AW-1:0] iaddr_o,
    input  logic [19:0]   idata_i,
    output logic          crd_o,
    output logic [AW-1:0] caddr_rd_o,
    input  logic [19:0]   cdata_rd_i,
    output logic          cwr_o,
    output logic [AW-1:0] caddr_wr_o,
    output logic [19:0]   cdata_wr_o,
    output logic [3:0]    csel_o
);
    localparam int PW = AW / 2;
    localparam int IW = PW + 2;
    localparam logic [PW-1:0] XMAX = PW'(IMG_W - 1);
    localparam logic [PW-1:0] PMAX = PW'(IMG_W / 2 - 1);
    localparam logic [1:0]    CMAX = 2'(NCH - 1);

    typedef enum logic [2:0] {IDLE, CONV_RD, CONV_WR, POOL_RD, POOL_WR, FLAT_WR, DONE} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      y_q, y_d, x_q, x_d;
    logic [3:0]         t_q, t_d;
    logic [1:0]         c_q, c_d, k_q, k_d;
    logic               mode_q, mode_d;
    logic [19:0]        max_q, max_d;
    logic signed [39:0] acc_q [NCH];
    logic signed [39:0] acc_d [NCH];
    logic [19:0]        w_q [NCH][10];

    logic signed [39:0] prod [NCH];
    logic signed [39:0] bias_ext [NCH];
    logic [19:0]        conv_res [NCH];
    logic [19:0]        conv_sel;
    logic [1:0]         tap_r, tap_c;
    logic [IW-1:0]      iy, ix;
    logic               pad, pool_next;
    logic signed [19:0] pix;

    always_comb begin
        if (t_q < 4'd3) begin
            tap_r = 2'd0;
            tap_c = t_q[1:0];
        end else if (t_q < 4'd6) begin
            tap_r = 2'd1;
            tap_c = 2'(t_q - 4'd3);
        end else begin
            tap_r = 2'd2;
            tap_c = 2'(t_q - 4'd6);
        end
    end

    // Neighbour coordinates carry two spare bits: MSB flags -1, next bit flags IMG_W.
    assign iy      = {2'b00, y_q} + IW'(tap_r) - IW'(1);
    assign ix      = {2'b00, x_q} + IW'(tap_c) - IW'(1);
    assign pad     = iy[IW-1] | iy[PW] | ix[IW-1] | ix[PW];
    assign pix     = pad ? 20'sd0 : $signed(idata_i);
    assign iaddr_o = (state_q == CONV_RD && !pad) ? {iy[PW-1:0], ix[PW-1:0]} : '0;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [24:0] rnd_hi;
        assign prod[gi]     = 40'($signed(w_q[gi][t_q])) * 40'(pix);
        assign bias_ext[gi] = {{4{w_q[gi][9][19]}}, w_q[gi][9], 16'h0};
        // Bits [40:16] of (acc + 0.5 LSB): sign, overflow field, then the Q4.16 result.
        assign rnd_hi       = 25'(({acc_q[gi][39], acc_q[gi]} + 41'd32768) >> 16);
        assign conv_res[gi] = rnd_hi[24] ? 20'h0 :
                              (|rnd_hi[23:19]) ? 20'h7FFFF : rnd_hi[19:0];
    end

    always_comb begin
        conv_sel = '0;
        for (int i = 0; i < NCH; i++)
            if (c_q == 2'(i)) conv_sel = conv_res[i];
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            for (int i = 0; i < NCH; i++)
                for (int j = 0; j < 10; j++) w_q[i][j] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                for (int j = 0; j < 10; j++)
                    if (wld_i && !busy_o && wch_i == 2'(i) && widx_i == 4'(j))
                        w_q[i][j] <= wdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d = y_q;  x_d = x_q;  t_d = t_q;  c_d = c_q;  k_d = k_q;
        mode_d = mode_q;
        max_d = max_q;
        for (int i = 0; i < NCH; i++) acc_d[i] = acc_q[i];
        busy_o = 1'b0;  done_o = 1'b0;  crd_o = 1'b0;  cwr_o = 1'b0;
        csel_o = '0;  caddr_rd_o = '0;  caddr_wr_o = '0;  cdata_wr_o = '0;
        pool_next = 1'b0;
        unique case (state_q)
            IDLE: if (ready_i) begin
                state_d = CONV_RD;
                y_d = '0;  x_d = '0;  t_d = '0;  c_d = '0;  k_d = '0;
                mode_d = mode_i;
            end
            CONV_RD: begin
                busy_o = 1'b1;
                for (int i = 0; i < NCH; i++)
                    acc_d[i] = ((t_q == 4'd0) ? bias_ext[i] : acc_q[i]) + prod[i];
                t_d = t_q + 4'd1;
                if (t_q == 4'd8) begin
                    state_d = CONV_WR;
                    t_d = '0;
                    c_d = '0;
                end
            end
            CONV_WR: begin
                busy_o = 1'b1;  cwr_o = 1'b1;
                csel_o = 4'd1 + {2'b00, c_q};
                caddr_wr_o = {y_q, x_q};
                cdata_wr_o = conv_sel;
                c_d = c_q + 2'd1;
                if (c_q == CMAX) begin
                    c_d = '0;
                    x_d = x_q + 1'b1;
                    state_d = CONV_RD;
                    if (x_q == XMAX) begin
                        y_d = y_q + 1'b1;
                        if (y_q == XMAX) begin
                            y_d = '0;  k_d = '0;
                            state_d = mode_q ? POOL_RD : DONE;
                        end
                    end
                end
            end
            POOL_RD: begin
                busy_o = 1'b1;  crd_o = 1'b1;
                csel_o = 4'd1 + {2'b00, c_q};
                caddr_rd_o = {y_q[PW-2:0], k_q[1], x_q[PW-2:0], k_q[0]};
                max_d = (k_q == 2'd0 || cdata_rd_i > max_q) ? cdata_rd_i : max_q;
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = POOL_WR;
            end
            POOL_WR: begin
                busy_o = 1'b1;  cwr_o = 1'b1;
                csel_o = 4'd5 + {2'b00, c_q};
                caddr_wr_o = AW'({y_q[PW-2:0], x_q[PW-2:0]});
                cdata_wr_o = max_q;
`ifdef CONV_POOL_FLATTEN_EN
                state_d = FLAT_WR;
`else
                pool_next = 1'b1;
`endif
            end
`ifdef CONV_POOL_FLATTEN_EN
            FLAT_WR: begin
                busy_o = 1'b1;  cwr_o = 1'b1;
                csel_o = 4'd9;
                caddr_wr_o = AW'({y_q[PW-2:0], x_q[PW-2:0]}) * AW'(NCH) + AW'(c_q);
                cdata_wr_o = max_q;
                pool_next = 1'b1;
            end
`endif
            DONE: begin
                done_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Pool raster: px, then py, then channel.
        if (pool_next) begin
            state_d = POOL_RD;
            k_d = '0;
            x_d = x_q + 1'b1;
            if (x_q == PMAX) begin
                x_d = '0;
                y_d = y_q + 1'b1;
                if (y_q == PMAX) begin
                    y_d = '0;
                    c_d = c_q + 2'd1;
                    if (c_q == CMAX) begin
                        c_d = '0;
                        state_d = DONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            state_q <= IDLE;
            y_q <= '0;  x_q <= '0;  t_q <= '0;  c_q <= '0;  k_q <= '0;
            mode_q <= 1'b0;
            max_q <= '0;
            for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
        end else begin
            state_q <= state_d;
            y_q <= y_d;  x_q <= x_d;  t_q <= t_d;  c_q <= c_d;  k_q <= k_d;
            mode_q <= mode_d;
            max_q <= max_d;
            for (int i = 0; i < NCH; i++) acc_q[i] <= acc_d[i];
        end
    end
endmodule

// File: tb/tb_conv_pool_engine.sv
// Scoreboard bench for conv_pool_engine on an 8x8 image with two channels.
module tb_conv_pool_engine;
    localparam int W    = 8;
    localparam int AW   = 6;
    localparam int NCH  = 2;
    localparam int NPIX = W * W;
    localparam int PW2  = W / 2;
`ifdef CONV_POOL_FLATTEN_EN
    localparam int POOL_CYC = 6;
`else
    localparam int POOL_CYC = 5;
`endif

    logic          clk = 1'b0;
    logic          reset_i, ready_i, mode_i, wld_i;
    logic [1:0]    wch_i;
    logic [3:0]    widx_i;
    logic [19:0]   wdata_i, idata_i, cdata_rd_i, cdata_wr_o;
    logic          busy_o, done_o, crd_o, cwr_o;
    logic [AW-1:0] iaddr_o, caddr_rd_o, caddr_wr_o;
    logic [3:0]    csel_o;

    always #5 clk = ~clk;

    conv_pool_engine #(.IMG_W(W), .AW(AW), .NCH(NCH)) dut (
        .clk(clk), .reset_i(reset_i), .ready_i(ready_i), .mode_i(mode_i),
        .busy_o(busy_o), .done_o(done_o), .wld_i(wld_i), .wch_i(wch_i),
        .widx_i(widx_i), .wdata_i(wdata_i), .iaddr_o(iaddr_o), .idata_i(idata_i),
        .crd_o(crd_o), .caddr_rd_o(caddr_rd_o), .cdata_rd_i(cdata_rd_i),
        .cwr_o(cwr_o), .caddr_wr_o(caddr_wr_o), .cdata_wr_o(cdata_wr_o),
        .csel_o(csel_o)
    );

    logic [19:0] img [NPIX];
    logic [19:0] mem [16][NPIX];
    logic [19:0] wm  [NCH][10];

    assign idata_i    = img[iaddr_o];
    assign cdata_rd_i = crd_o ? mem[csel_o][caddr_rd_o] : 20'h0;
    always @(posedge clk) if (cwr_o) mem[csel_o][caddr_wr_o] <= cdata_wr_o;

    typedef struct packed {
        logic [3:0]    sel;
        logic [AW-1:0] addr;
        logic [19:0]   data;
    } wr_t;
    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t got;
        wr_t e;
        if (reset_i && cwr_o) begin
            got = '{sel: csel_o, addr: caddr_wr_o, data: cdata_wr_o};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got sel=%0d addr=%0d data=0x%0h expected none",
                         csel_o, caddr_wr_o, cdata_wr_o);
            end else begin
                e = exp_q.pop_front();
                check("wr {sel,addr,data}", got, e);
            end
        end
    end

    function automatic longint sx20(input logic [19:0] v);
        return longint'($signed(v));
    endfunction

    // Plain-arithmetic reference: padded 3x3 dot product, 40-bit wrap, round, ReLU, saturate.
    function automatic logic [19:0] conv_ref(input int ch, input int y, input int x);
        longint acc;
        longint r;
        acc = sx20(wm[ch][9]) * 65536;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                int iy;
                int ix;
                iy = y + dy - 1;
                ix = x + dx - 1;
                if (iy >= 0 && iy < W && ix >= 0 && ix < W)
                    acc += sx20(wm[ch][dy*3+dx]) * sx20(img[iy*W+ix]);
            end
        end
        acc = (acc <<< 24) >>> 24;
        r = acc + 32768;
        if (r < 0) return 20'h0;
        if (r >= (longint'(1) << 35)) return 20'h7FFFF;
        return 20'(r >>> 16);
    endfunction

    task automatic expect_run(input bit m);
        logic [19:0] l0 [NCH][NPIX];
        logic [19:0] mx;
        wr_t e;
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++)
                for (int c = 0; c < NCH; c++) begin
                    l0[c][y*W+x] = conv_ref(c, y, x);
                    e = '{sel: 4'(1 + c), addr: AW'(y*W + x), data: l0[c][y*W+x]};
                    exp_q.push_back(e);
                end
        if (m) begin
            for (int c = 0; c < NCH; c++)
                for (int py = 0; py < PW2; py++)
                    for (int px = 0; px < PW2; px++) begin
                        mx = 20'h0;
                        for (int i = 0; i < 2; i++)
                            for (int j = 0; j < 2; j++)
                                if (l0[c][(2*py+i)*W + 2*px+j] > mx) mx = l0[c][(2*py+i)*W + 2*px+j];
                        e = '{sel: 4'(5 + c), addr: AW'(py*PW2 + px), data: mx};
                        exp_q.push_back(e);
`ifdef CONV_POOL_FLATTEN_EN
                        e = '{sel: 4'd9, addr: AW'((py*PW2 + px)*NCH + c), data: mx};
                        exp_q.push_back(e);
`endif
                    end
        end
    endtask

    task automatic load_w(input int ch, input int idx, input logic [19:0] v);
        @(negedge clk);
        wld_i = 1'b1;  wch_i = 2'(ch);  widx_i = 4'(idx);  wdata_i = v;
        @(negedge clk);
        wld_i = 1'b0;
        if (ch < NCH && idx <= 9) wm[ch][idx] = v;
    endtask

    task automatic set_ch(input int ch, input logic [19:0] tap, input logic [19:0] centre,
                          input logic [19:0] bias);
        for (int t = 0; t < 9; t++) load_w(ch, t, (t == 4) ? centre : tap);
        load_w(ch, 9, bias);
    endtask

    task automatic run(input bit m, input bit noisy);
        int cyc;
        int it;
        int limit;
        cyc = 0;
        it = 0;
        limit = NPIX*(9 + NCH) + (m ? NCH*PW2*PW2*POOL_CYC : 0);
        expect_run(m);
        @(negedge clk);
        ready_i = 1'b1;  mode_i = m;
        @(negedge clk);
        ready_i = 1'b0;  mode_i = ~m;
        check("start_busy", busy_o, 1);
        check("start_iaddr", iaddr_o, 0);
        while (!done_o && it < limit + 50) begin
            if (busy_o) cyc++;
            if (noisy && cyc < limit - 4) begin
                ready_i = (cyc % 37 == 5);
                wld_i   = (cyc % 29 == 3);
                wch_i   = 2'(cyc % 2);
                widx_i  = 4'(cyc % 10);
                wdata_i = 20'h7FFFF;
            end
            @(negedge clk);
            it++;
        end
        ready_i = 1'b0;
        wld_i = 1'b0;
        check("done_seen", done_o, 1);
        check("busy_cycles", cyc, limit);
        check("busy_in_done", busy_o, 0);
        @(negedge clk);
        check("done_one_cycle", done_o, 0);
        check("idle_busy", busy_o, 0);
        check("sb_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_crd"}, crd_o, 0);
        check({tag, "_cwr"}, cwr_o, 0);
        check({tag, "_csel"}, csel_o, 0);
        check({tag, "_caddr_wr"}, caddr_wr_o, 0);
        check({tag, "_caddr_rd"}, caddr_rd_o, 0);
        check({tag, "_cdata_wr"}, cdata_wr_o, 0);
        check({tag, "_iaddr"}, iaddr_o, 0);
    endtask

    initial begin
        logic [19:0] v;
        reset_i = 1'b0;  ready_i = 1'b0;  mode_i = 1'b0;  wld_i = 1'b0;
        wch_i = '0;  widx_i = '0;  wdata_i = '0;
        for (int c = 0; c < NCH; c++) for (int j = 0; j < 10; j++) wm[c][j] = '0;
        for (int i = 0; i < NPIX; i++) img[i] = '0;
        for (int s = 0; s < 16; s++) for (int i = 0; i < NPIX; i++) mem[s][i] = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        reset_i = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle");

        // Identity on ch0, negative bias on ch1, mode 0.
        set_ch(0, 20'h0, 20'h10000, 20'h0);
        set_ch(1, 20'h0, 20'h0, 20'hF0000);
        for (int i = 0; i < NPIX; i++) img[i] = 20'(32'h100 * (i % W));
        run(1'b0, 1'b0);
        check("A_l0c0_(2,3)", mem[1][2*W+3], 20'h00300);
        check("A_l0c0_(7,7)", mem[1][7*W+7], 20'h00700);
        check("A_l0c1_(4,4)", mem[2][4*W+4], 20'h0);

        // Half-weight box filter on a constant image: counts taps inside the image.
        set_ch(0, 20'h08000, 20'h08000, 20'h0);
        set_ch(1, 20'h08000, 20'h08000, 20'h0);
        for (int i = 0; i < NPIX; i++) img[i] = 20'h10000;
        run(1'b0, 1'b0);
        check("B_(0,0)", mem[1][0], 20'h20000);
        check("B_(0,5)", mem[1][5], 20'h30000);
        check("B_(5,5)", mem[1][5*W+5], 20'h48000);

        // Saturation on ch0, negative taps clipped to zero on ch1.
        set_ch(0, 20'h7FFFF, 20'h7FFFF, 20'h0);
        set_ch(1, 20'hFFFF0, 20'hFFFF0, 20'h0);
        for (int i = 0; i < NPIX; i++) img[i] = 20'h7FFFF;
        run(1'b0, 1'b0);
        check("C_sat_(3,3)", mem[1][3*W+3], 20'h7FFFF);
        check("C_neg_(3,3)", mem[2][3*W+3], 20'h0);

        // Pool: block (0,0) of ch0 holds 3,9,1,4; ch1 doubles it.
        set_ch(0, 20'h0, 20'h10000, 20'h0);
        set_ch(1, 20'h0, 20'h20000, 20'h0);
        for (int i = 0; i < NPIX; i++) img[i] = 20'($urandom);
        img[0] = 20'd3;  img[1] = 20'd9;  img[W] = 20'd1;  img[W+1] = 20'd4;
        run(1'b1, 1'b0);
        check("D_pool_c0", mem[5][0], 20'd9);
        check("D_pool_c1", mem[6][0], 20'd18);
`ifdef CONV_POOL_FLATTEN_EN
        check("D_flat_c0", mem[9][0], 20'd9);
        check("D_flat_c1", mem[9][1], 20'd18);
`endif

        // Reset in the middle of CONV_RD, then restart from scratch with cleared weights.
        @(negedge clk);
        ready_i = 1'b1;  mode_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("midrst");
        reset_i = 1'b1;
        for (int c = 0; c < NCH; c++) for (int j = 0; j < 10; j++) wm[c][j] = '0;
        run(1'b0, 1'b0);

        // Random weights and image; ignored loads before, ready/wld noise during.
        for (int c = 0; c < NCH; c++)
            for (int t = 0; t < 10; t++) begin
                v = 20'($urandom_range(0, 32'h1FFFF));
                if ($urandom % 2 == 1) v = -v;
                load_w(c, t, v);
            end
        load_w(3, 0, 20'h7FFFF);
        load_w(0, 12, 20'h7FFFF);
        for (int i = 0; i < NPIX; i++) img[i] = 20'($urandom);
        run(1'b1, 1'b1);
        run(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
